riscv_imem_responder: RTL and testbench
=======================================

Name: riscv_imem_responder

Overview:
- Target (responder) side of the core's instruction-fetch req/gnt/rvalid protocol; sits between the fetch unit and the single-port instruction SRAM.
- Grants requests subject to SRAM arbitration and an outstanding-transaction limit, drives the SRAM read, and returns rvalid/rdata at a fixed latency.
- Flags out-of-range fetches and raises a priority request to the SRAM arbiter when fetch is starved.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0.
- MEM_DEPTH, 4096, SRAM depth in 32-bit words (power of two).
- MEM_AW, $clog2(MEM_DEPTH), SRAM word-address width.
- SRAM_LAT, 1, SRAM read latency in cycles, range 1..4.
- MAX_OUTSTANDING, 1, granted-but-unanswered transaction limit, range 1..SRAM_LAT.
- STARVE_MAX, 8, consecutive denied-request cycles before prio_o asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  byte address, word aligned (bits [1:0] ignored).
- instr_gnt_o  out  1  grant, combinational, same cycle as the request.
- instr_rvalid_o  out  1  response valid; exactly one per grant.
- instr_rdata_o  out  32  response data.
- instr_err_o  out  1  out-of-range flag, coincident with rvalid.
- err_addr_o  out  32  address of the most recent out-of-range fetch.
- mem_ce_o  out  1  SRAM read enable.
- mem_addr_o  out  MEM_AW  SRAM word address.
- mem_rdata_i  in  32  SRAM read data, valid SRAM_LAT cycles after mem_ce_o.
- mem_busy_i  in  1  SRAM claimed by another master this cycle.
- prio_o  out  1  fetch-starvation priority request to the arbiter.

Behaviour:
- Reset (synchronous, active-high; clk and rst as named above): gnt, rvalid, err, mem_ce, prio = 0; rdata_o, err_addr_o, mem_addr_o = 0.
  - Latency pipe, outstanding count and starve counter cleared.
  - Reset mid-transaction drops all in-flight responses; none is emitted after reset.
- Outstanding count cnt (width $clog2(MAX_OUTSTANDING+1)): +1 on grant, -1 on rvalid, unchanged when both occur in the same cycle.
- Grant rule: instr_gnt_o = instr_req_i & ~mem_busy_i & (cnt < MAX_OUTSTANDING | instr_rvalid_o).
  - Back-to-back at the limit is therefore allowed: grant in the cycle of an rvalid.
- In range means BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH, computed in 33-bit arithmetic so there is no wrap at 2^32.
- On a grant:
  - In range: mem_ce_o = 1 and mem_addr_o = (addr - BASE_ADDR)[MEM_AW+1:2] in the same cycle.
  - Out of range: mem_ce_o = 0.
  - mem_addr_o holds its previous value when mem_ce_o = 0.
- Latency pipe: SRAM_LAT-deep shift register of {valid, oob}. It shifts every cycle; stage 0 is loaded with {gnt, oob}.
- Response timing: grant at cycle T gives instr_rvalid_o = 1 at T+SRAM_LAT exactly. Rvalid cannot be backpressured; the requester must accept it.
- Response data:
  - When rvalid and not oob: instr_rdata_o = mem_rdata_i (combinational pass-through).
  - When rvalid and oob: instr_rdata_o = 0 and instr_err_o = 1.
  - When rvalid = 0: instr_rdata_o holds the last delivered value (registered copy).
- err_addr_o loads instr_addr_i on an out-of-range grant.
- Starve counter: increments while instr_req_i & ~instr_gnt_o, saturating at STARVE_MAX; clears on a grant or when req drops.
  - prio_o = (counter == STARVE_MAX), registered.
  - prio_o deasserts the cycle after the grant.
- Requester behaviour: the requester may drop req or change addr without a grant (abort). This is legal and no transaction is created.
- Simultaneous grant and mem_busy_i cannot occur: busy gates the grant.
- Assertions (bench):
  - No rvalid while cnt == 0.
  - cnt never exceeds MAX_OUTSTANDING.
  - Each rvalid corresponds to exactly one earlier grant.

Decomposition:
- Shared package riscv_imem_pkg: BASE_ADDR/MEM_DEPTH defaults, the resp_pipe_t struct {valid, oob}, and the SRAM_LAT bounds.
- One natural sub-module: riscv_imem_lat_pipe, the parameterised SRAM_LAT-deep valid/oob shift register with synchronous clear.
- The grant logic, counters and data muxing stay in the top module.

Test Plan:
- Single fetch, SRAM_LAT=1: req, addr=0x100, SRAM word 0x40 = 0x00A00093 → gnt at T, mem_addr=0x40 at T, rvalid at T+1 with rdata 0x00A00093, err=0.
- Streaming, MAX_OUTSTANDING=1: req held, addr 0x0, 0x4, 0x8 → gnt T, T+1, T+2; rvalid T+1, T+2, T+3 with words 0, 1, 2; no bubbles.
- Arbitration starvation, STARVE_MAX=8: mem_busy_i=1 for 12 cycles with req high → no gnt; prio_o=1 from the 9th cycle; drop busy → gnt that cycle; prio_o=0 the cycle after.
- Out of range, MEM_DEPTH=4096: addr 0x4000 → gnt, mem_ce=0, rvalid at T+1 with rdata=0, err=1, err_addr_o=0x4000.
- SRAM_LAT=3, MAX_OUTSTANDING=2: three consecutive requests → gnt T, T+1; third denied until rvalid at T+3, then granted at T+3; rvalid at T+3, T+4, T+6.
- Reset mid-flight, SRAM_LAT=2: grant at T, rst=1 at T+1 → no rvalid at T+2; all outputs 0 at T+2; the first grant after reset is accepted normally.

Source files
------------

// File: rtl/riscv_imem_pkg.sv
// Shared definitions for the instruction-memory responder slice.
package riscv_imem_pkg;

   localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0000;
   localparam int unsigned IMEM_DEPTH     = 4096;
   localparam int unsigned SRAM_LAT_MIN   = 1;
   localparam int unsigned SRAM_LAT_MAX   = 4;

   typedef struct packed {
      logic valid;
      logic oob;
   } resp_pipe_t;

endpackage

// File: rtl/riscv_imem_lat_pipe.sv
// Fixed-depth {valid, oob} shift register that times fetch responses to the SRAM latency.
module riscv_imem_lat_pipe
   import riscv_imem_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic       clk,
   input  logic       clr,
   input  resp_pipe_t d,
   output resp_pipe_t q
);

   resp_pipe_t [DEPTH-1:0] stage;
   resp_pipe_t [DEPTH:0]   chain;

   // Input joins the bottom of the chain so DEPTH=1 needs no special case.
   assign chain = {stage, d};
   assign q     = chain[DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         stage <= '0;
      end else begin
         stage <= chain[DEPTH-1:0];
      end
   end

endmodule

// File: rtl/riscv_imem_responder.sv
// Responder side of the instruction-fetch req/gnt/rvalid protocol in front of the
// single-port instruction SRAM, with range checking and fetch-starvation priority.
module riscv_imem_responder
   import riscv_imem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = IMEM_BASE_ADDR,
   parameter int unsigned MEM_DEPTH       = IMEM_DEPTH,
   parameter int unsigned MEM_AW          = $clog2(MEM_DEPTH),
   parameter int unsigned SRAM_LAT        = 1,
   parameter int unsigned MAX_OUTSTANDING = 1,
   parameter int unsigned STARVE_MAX      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_req_i,
   input  logic [31:0]       instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic [31:0]       instr_rdata_o,
   output logic              instr_err_o,
   output logic [31:0]       err_addr_o,
   output logic              mem_ce_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_busy_i,
   output logic              prio_o
);

   localparam int unsigned   CW         = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
   localparam logic [32:0]   BASE33     = {1'b0, BASE_ADDR};
   localparam logic [32:0]   LIMIT33    = BASE33 + (33'(MEM_DEPTH) << 2);

   logic [CW-1:0]     cnt;
   logic [SW-1:0]     starve, starve_d;
   logic [32:0]       addr33;
   logic              in_range;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [31:0]       rdata_q;
   resp_pipe_t        pipe_in, pipe_out;

   // 33-bit compare keeps a window ending exactly at 2^32 from wrapping to empty.
   assign addr33   = {1'b0, instr_addr_i};
   assign in_range = (addr33 >= BASE33) && (addr33 < LIMIT33);

   assign instr_gnt_o = ~rst & instr_req_i & ~mem_busy_i & ((cnt < CNT_MAX) | instr_rvalid_o);
   assign mem_ce_o    = instr_gnt_o & in_range;
   assign mem_addr_o  = mem_ce_o ? MEM_AW'((addr33 - BASE33) >> 2) : mem_addr_q;

   assign pipe_in = '{valid: instr_gnt_o, oob: ~in_range};

   riscv_imem_lat_pipe #(
      .DEPTH(SRAM_LAT)
   ) u_lat_pipe (
      .clk(clk),
      .clr(rst),
      .d  (pipe_in),
      .q  (pipe_out)
   );

   assign instr_rvalid_o = pipe_out.valid;
   assign instr_err_o    = pipe_out.valid & pipe_out.oob;

   always_comb begin
      instr_rdata_o = rdata_q;
      if (pipe_out.valid) begin
         instr_rdata_o = pipe_out.oob ? '0 : mem_rdata_i;
      end
   end

   always_comb begin
      starve_d = '0;
      if (instr_req_i & ~instr_gnt_o) begin
         starve_d = (starve == STARVE_SAT) ? starve : starve + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         starve     <= '0;
         prio_o     <= 1'b0;
         err_addr_o <= '0;
         mem_addr_q <= '0;
         rdata_q    <= '0;
      end else begin
         case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
         starve     <= starve_d;
         prio_o     <= (starve_d == STARVE_SAT);
         mem_addr_q <= mem_addr_o;
         if (instr_gnt_o & ~in_range) begin
            err_addr_o <= instr_addr_i;
         end
         if (instr_rvalid_o) begin
            rdata_q <= instr_rdata_o;
         end
      end
   end

endmodule

// File: tb/tb_riscv_imem_responder.sv
// Randomized bench for riscv_imem_responder against a transaction-queue reference model.
module tb_riscv_imem_responder;

   localparam logic [31:0] BASE  = 32'hFFFF_C000;
   localparam int unsigned DEPTH = 4096;
   localparam int unsigned AW    = 12;
   localparam int unsigned LAT   = 3;
   localparam int unsigned MAXO  = 2;
   localparam int unsigned SMAX  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic [31:0]   addr = '0;
   logic          busy = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          gnt, rvalid, err, mem_ce, prio;
   logic [31:0]   rdata, err_addr;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   riscv_imem_responder #(
      .BASE_ADDR      (BASE),
      .MEM_DEPTH      (DEPTH),
      .SRAM_LAT       (LAT),
      .MAX_OUTSTANDING(MAXO),
      .STARVE_MAX     (SMAX)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_req_i   (req),
      .instr_addr_i  (addr),
      .instr_gnt_o   (gnt),
      .instr_rvalid_o(rvalid),
      .instr_rdata_o (rdata),
      .instr_err_o   (err),
      .err_addr_o    (err_addr),
      .mem_ce_o      (mem_ce),
      .mem_addr_o    (mem_addr),
      .mem_rdata_i   (mem_rdata),
      .mem_busy_i    (busy),
      .prio_o        (prio)
   );

   typedef struct {
      int unsigned due;
      bit          oob;
      int unsigned word;
   } resp_t;

   resp_t         pend[$];
   int unsigned   grant_cyc[$];
   logic [31:0]   mem [DEPTH];
   logic [31:0]   sram_out [int unsigned];
   int unsigned   cyc = 0;
   int unsigned   starve = 0;
   logic [31:0]   rdata_hold = '0;
   logic [31:0]   err_addr_hold = '0;
   logic [AW-1:0] maddr_hold = '0;
   bit            last_gnt = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%h expected 0x%h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * DEPTH));
   endfunction

   function automatic int unsigned word_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned sel = $urandom_range(0, 7);
      logic [31:0] lo  = 32'($urandom_range(0, 3));
      case (sel)
         4:       return BASE - 32'd4 + lo;
         5:       return 32'hFFFF_FFFC;
         6:       return $urandom;
         7:       return BASE;
         default: return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + lo;
      endcase
   endfunction

   // One clock cycle: drive inputs after the edge, check at the falling edge, advance the model.
   task automatic step(input bit r, input bit q, input logic [31:0] a, input bit b);
      resp_t         head;
      bit            ev, eg, ir;
      logic [31:0]   erd;
      logic [AW-1:0] ema;
      @(posedge clk);
      cyc++;
      #1;
      rst  = r;
      req  = q;
      addr = a;
      busy = b;
      mem_rdata = sram_out.exists(cyc) ? sram_out[cyc] : $urandom;
      @(negedge clk);
      ir = in_window(a);
      ev = (pend.size() > 0) && (pend[0].due == cyc);
      head = '{0, 1'b0, 0};
      if (ev) head = pend[0];
      eg  = !r && q && !b && ((pend.size() < MAXO) || ev);
      erd = !ev ? rdata_hold : (head.oob ? 32'h0 : mem[head.word]);
      ema = (eg && ir) ? AW'(word_of(a)) : maddr_hold;

      check_eq("gnt", gnt, eg);
      check_eq("rvalid", rvalid, ev);
      check_eq("rdata", rdata, erd);
      check_eq("err", err, ev && head.oob);
      check_eq("err_addr", err_addr, err_addr_hold);
      check_eq("mem_ce", mem_ce, eg && ir);
      check_eq("mem_addr", mem_addr, ema);
      check_eq("prio", prio, starve == SMAX);

      if (mem_ce === 1'b1) sram_out[cyc + LAT] = mem[mem_addr];

      if (rvalid === 1'b1) begin
         check_eq("rvalid_orphan", grant_cyc.size() > 0, 1);
         if (grant_cyc.size() > 0) check_eq("rvalid_latency", cyc - grant_cyc.pop_front(), LAT);
      end
      if (gnt === 1'b1) grant_cyc.push_back(cyc);
      check_eq("outstanding_max", grant_cyc.size() <= MAXO, 1);

      last_gnt = eg;
      if (r) begin
         pend.delete();
         grant_cyc.delete();
         rdata_hold    = '0;
         err_addr_hold = '0;
         maddr_hold    = '0;
         starve        = 0;
      end else begin
         if (ev) begin
            rdata_hold = erd;
            void'(pend.pop_front());
         end
         if (eg) begin
            pend.push_back('{cyc + LAT, !ir, ir ? word_of(a) : 0});
            if (!ir) err_addr_hold = a;
         end
         maddr_hold = ema;
         starve = (q && !eg) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic fetch(input logic [31:0] a);
      int unsigned n = 0;
      do begin
         step(1'b0, 1'b1, a, 1'b0);
         n++;
      end while (!last_gnt && n < 16);
      check_eq("fetch_granted", last_gnt, 1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[12'h040] = 32'h00A00093;
      repeat (2) @(posedge clk);

      step(1'b1, 1'b0, 32'h0, 1'b0);
      fetch(BASE + 32'h100);
      idle(4);
      for (int i = 0; i < 5; i++) fetch(BASE + 32'(i) * 4);
      fetch(32'h0000_4000);
      fetch(BASE - 32'd4);
      fetch(32'hFFFF_FFFC);
      fetch(BASE);
      idle(4);
      repeat (12) step(1'b0, 1'b1, BASE + 32'h8, 1'b1);
      step(1'b0, 1'b1, BASE + 32'h8, 1'b0);
      idle(3);
      fetch(BASE + 32'h10);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      idle(4);
      fetch(BASE + 32'h14);
      idle(4);

      repeat (3000) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, rand_addr(),
              $urandom_range(0, 3) == 0);
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
